// File: rtl/late_result_scoreboard.sv
// Late-result scoreboard: each slot counts down the ID stall cycles owed to a producer's consumers.
// Define HAZ_STATS_EN to build the saturating bubble-cycle counter behind stall_cnt.
module late_result_scoreboard #(
  parameter int NSRC  = 2,
  parameter int REGW  = 5,
  parameter int LATW  = 3,
  parameter int NSLOT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [NSRC*REGW-1:0] id_src,
  input  logic [NSRC-1:0]      id_src_used,
  input  logic [REGW-1:0]      id_rw,
  input  logic [LATW-1:0]      id_lat,
  input  logic                 advance,
  input  logic                 flush,
  output logic                 bubble,
  output logic                 full,
  output logic [31:0]          stall_cnt
);

  logic [REGW-1:0]  rw_q  [NSLOT];
  logic [REGW-1:0]  rw_d  [NSLOT];
  logic [LATW-1:0]  cnt_q [NSLOT];
  logic [LATW-1:0]  cnt_d [NSLOT];

  logic             any_match;
  logic             need_slot;
  logic             issue;
  logic [NSLOT-1:0] free_vec;
  logic [NSLOT-1:0] hit_vec;
  logic [NSLOT-1:0] first_free;
  logic [NSLOT-1:0] alloc_sel;

  always_comb begin
    any_match = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      for (int s = 0; s < NSLOT; s++) begin
        if (id_src_used[k] && (id_src[k*REGW +: REGW] != '0) &&
            (cnt_q[s] != '0) && (rw_q[s] == id_src[k*REGW +: REGW]))
          any_match = 1'b1;
      end
    end
  end

  // A slot at cnt 1 drains this edge, so it is already reusable.
  always_comb begin
    for (int s = 0; s < NSLOT; s++) begin
      free_vec[s] = (cnt_q[s] <= LATW'(1));
      hit_vec[s]  = (cnt_q[s] != '0) && (rw_q[s] == id_rw);
    end
  end

  always_comb begin
    logic taken;
    taken      = 1'b0;
    first_free = '0;
    for (int s = 0; s < NSLOT; s++) begin
      if (free_vec[s] && !taken) begin
        first_free[s] = 1'b1;
        taken         = 1'b1;
      end
    end
  end

  // Re-issuing a tracked destination reloads its slot so each register has one entry.
  assign alloc_sel = (|hit_vec) ? hit_vec : first_free;
  assign full      = ~(|free_vec);
  assign need_slot = (id_lat != '0) && (id_rw != '0);
  assign bubble    = id_valid && !flush && (any_match || (full && need_slot));
  assign issue     = id_valid && advance && !bubble && !flush;

  always_comb begin
    for (int s = 0; s < NSLOT; s++) begin
      rw_d[s]  = rw_q[s];
      cnt_d[s] = (cnt_q[s] != '0) ? (cnt_q[s] - LATW'(1)) : '0;
      if (flush) begin
        cnt_d[s] = '0;
      end else if (issue && need_slot && alloc_sel[s]) begin
        cnt_d[s] = id_lat;
        rw_d[s]  = id_rw;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NSLOT; s++) cnt_q[s] <= '0;
    end else begin
      for (int s = 0; s < NSLOT; s++) cnt_q[s] <= cnt_d[s];
    end
  end

  // Register tags are only meaningful while cnt != 0, so they carry no reset.
  always_ff @(posedge clk) begin
    for (int s = 0; s < NSLOT; s++) rw_q[s] <= rw_d[s];
  end

`ifdef HAZ_STATS_EN
  logic [31:0] stall_q;
  logic [31:0] stall_d;

  always_comb begin
    stall_d = stall_q;
    if (bubble && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_late_result_scoreboard.sv
// Directed bench for late_result_scoreboard; stall_cnt expectations follow HAZ_STATS_EN.
module tb_late_result_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [9:0]  id_src;
  logic [1:0]  id_src_used;
  logic [4:0]  id_rw;
  logic [2:0]  id_lat;
  logic        advance;
  logic        flush;
  logic        bubble;
  logic        full;
  logic [31:0] stall_cnt;

  int total = 0;
  int bad   = 0;

`ifdef HAZ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  late_result_scoreboard dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_src      (id_src),
    .id_src_used (id_src_used),
    .id_rw       (id_rw),
    .id_lat      (id_lat),
    .advance     (advance),
    .flush       (flush),
    .bubble      (bubble),
    .full        (full),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_stall(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                       input logic [1:0] used, input logic [4:0] rw,
                       input logic [2:0] lat, input logic adv);
    id_valid    = v;
    id_src      = {s1, s0};
    id_src_used = used;
    id_rw       = rw;
    id_lat      = lat;
    advance     = adv;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 3'd0, 1'b1);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    idle();
    repeat (2) tick();
    drive(1'b1, 5'd3, 5'd4, 2'b11, 5'd7, 3'd5, 1'b1);
    #1;
    chk("rst_bubble", 32'(bubble), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_stall", stall_cnt, 32'd0);
    idle();
    rst_n = 1'b1;
    tick();

    // MFC0 to $5 with latency 2, adjacent reader of $5
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 3'd2, 1'b1);
    #1 chk("t1_prod_bubble", 32'(bubble), 32'd0);
    tick();
    drive(1'b1, 5'd5, 5'd0, 2'b01, 5'd0, 3'd0, 1'b1);
    #1 chk("t1_bubble_c1", 32'(bubble), 32'd1);
    tick();
    #1 chk("t1_bubble_c2", 32'(bubble), 32'd1);
    tick();
    #1 chk("t1_release", 32'(bubble), 32'd0);
    tick();
    idle();
    #1 chk("t1_stall", stall_cnt, exp_stall(2));

    // $0 destination never allocates; unused operands never match
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 3'd3, 1'b1);
    tick();
    drive(1'b1, 5'd0, 5'd0, 2'b01, 5'd0, 3'd0, 1'b1);
    #1 chk("t2_r0_bubble_a", 32'(bubble), 32'd0);
    tick();
    #1 chk("t2_r0_bubble_b", 32'(bubble), 32'd0);
    chk("t2_full", 32'(full), 32'd0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 3'd2, 1'b1);
    tick();
    drive(1'b1, 5'd7, 5'd0, 2'b10, 5'd0, 3'd0, 1'b1);
    #1 chk("t2_unused_src", 32'(bubble), 32'd0);
    tick();
    idle();
    repeat (3) tick();

    // Fill all slots, then a producer waits for slot 0 to drain
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'd0, 5'd0, 2'b00, 5'(i), 3'd7, 1'b1);
      tick();
    end
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 3'd2, 1'b1);
    #1 chk("t3_full_c1", 32'(full), 32'd1);
    chk("t3_bubble_c1", 32'(bubble), 32'd1);
    tick();
    #1 chk("t3_bubble_c2", 32'(bubble), 32'd1);
    tick();
    #1 chk("t3_bubble_c3", 32'(bubble), 32'd1);
    tick();
    #1 chk("t3_full_free", 32'(full), 32'd0);
    chk("t3_bubble_free", 32'(bubble), 32'd0);
    tick();
    drive(1'b1, 5'd9, 5'd0, 2'b01, 5'd0, 3'd0, 1'b0);
    #1 chk("t3_r9_tracked", 32'(bubble), 32'd1);
    drive(1'b1, 5'd1, 5'd0, 2'b01, 5'd0, 3'd0, 1'b0);
    #1 chk("t3_r1_replaced", 32'(bubble), 32'd0);
    drive(1'b1, 5'd0, 5'd4, 2'b10, 5'd0, 3'd0, 1'b0);
    #1 chk("t3_r4_pending", 32'(bubble), 32'd1);
    idle();
    repeat (8) tick();
    #1 chk("t3_stall", stall_cnt, exp_stall(5));

    // Re-issue of $6 reloads the existing slot
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 3'd5, 1'b1);
    tick();
    idle();
    tick();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 3'd1, 1'b1);
    #1 chk("t4_reissue_bubble", 32'(bubble), 32'd0);
    tick();
    drive(1'b1, 5'd6, 5'd0, 2'b01, 5'd0, 3'd0, 1'b1);
    #1 chk("t4_bubble_c1", 32'(bubble), 32'd1);
    tick();
    #1 chk("t4_release", 32'(bubble), 32'd0);
    tick();
    idle();
    repeat (2) tick();

    // Flush with three slots valid and a dependent reader (via operand 1) in ID
    for (int i = 10; i <= 12; i++) begin
      drive(1'b1, 5'd0, 5'd0, 2'b00, 5'(i), 3'd7, 1'b1);
      tick();
    end
    drive(1'b1, 5'd0, 5'd11, 2'b10, 5'd14, 3'd3, 1'b1);
    #1 chk("t5_pre_bubble", 32'(bubble), 32'd1);
    tick();
    flush = 1'b1;
    #1 chk("t5_flush_bubble", 32'(bubble), 32'd0);
    tick();
    flush = 1'b0;
    #1 chk("t5_post_bubble", 32'(bubble), 32'd0);
    chk("t5_post_full", 32'(full), 32'd0);
    drive(1'b1, 5'd10, 5'd12, 2'b11, 5'd0, 3'd0, 1'b0);
    #1 chk("t5_slots_empty", 32'(bubble), 32'd0);
    drive(1'b1, 5'd14, 5'd0, 2'b01, 5'd0, 3'd0, 1'b0);
    #1 chk("t5_no_alloc_in_flush", 32'(bubble), 32'd0);
    drive(1'b1, 5'd0, 5'd11, 2'b10, 5'd14, 3'd3, 1'b1);
    tick();
    drive(1'b1, 5'd14, 5'd0, 2'b01, 5'd0, 3'd0, 1'b0);
    #1 chk("t5_reader_issued", 32'(bubble), 32'd1);
    idle();
    repeat (4) tick();
    #1 chk("t5_stall", stall_cnt, exp_stall(7));

    // Reset asserted mid-countdown
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd13, 3'd7, 1'b1);
    tick();
    drive(1'b1, 5'd13, 5'd0, 2'b01, 5'd0, 3'd0, 1'b1);
    #1 chk("t6_pre_bubble", 32'(bubble), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("t6_rst_bubble", 32'(bubble), 32'd0);
    chk("t6_rst_stall", stall_cnt, 32'd0);
    tick();
    rst_n = 1'b1;
    #1 chk("t6_post_bubble", 32'(bubble), 32'd0);
    tick();
    idle();
    #1 chk("t6_post_stall", stall_cnt, 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/late_result_scoreboard.md
# late_result_scoreboard

Parametrised successor to the fixed two-stage MFC0-use bubble logic. It sits beside the ID stage and tracks up to NSLOT in-flight producers whose results arrive late, such as MFC0, loads and multi-cycle mult/div. Each producer gets its own countdown, so the unit covers variable latency instead of a hardwired EX/MEM compare. It raises `bubble` while any used ID source register matches a pending producer, or while no slot is free for an ID instruction that needs one.

## Interface
- NSRC, 2: number of ID source register operands checked.
- REGW, 5: register index width.
- LATW, 3: latency field width; maximum latency is 2^LATW-1.
- NSLOT, 4: scoreboard entries.

- clk  in  1  pipeline clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_src  in  NSRC*REGW  source register indices; operand k is bits [k*REGW +: REGW].
- id_src_used  in  NSRC  bit k set means operand k is actually read.
- id_rw  in  REGW  destination register of the ID instruction.
- id_lat  in  LATW  ID-side stall cycles owed to consumers of this result; 0 means no slot is needed.
- advance  in  1  pipeline enable; the ID instruction moves to EX this edge if not bubbled.
- flush  in  1  exception/redirect; kills all tracked producers.
- bubble  out  1  combinational; hold ID and inject a NOP into EX.
- full  out  1  combinational; no allocatable slot.
- stall_cnt  out  32  bubble-cycle statistics (see Configuration).

## Operation
- Slot state: `rw[REGW]` and `cnt[LATW]`. A slot is valid when cnt != 0. Reset clears all cnt to 0.
- Match: operand k hits slot s when all hold:
  - id_src_used[k] = 1
  - src_k != 0
  - cnt_s != 0
  - rw_s == src_k
- Free slot: cnt <= 1, meaning it empties or is reusable this edge. `full` = no free slot.
- Bubble: `bubble` = id_valid & ~flush & (any match | (full & id_lat != 0 & id_rw != 0)).
- Issue: `issue` = id_valid & advance & ~bubble & ~flush.
- Each edge, every slot with cnt != 0 decrements by 1.
- On issue with id_lat != 0 and id_rw != 0:
  - If a valid slot already holds rw == id_rw, that slot is reloaded with cnt = id_lat. The youngest writer wins, so no duplicate entries exist.
  - Otherwise the lowest-index free slot is loaded with rw = id_rw and cnt = id_lat.
- Writes to r0 and id_lat = 0 never allocate.
- Flush: all cnt are cleared to 0 at the edge. Allocation and decrement are suppressed that edge.
- Invariant: at most one valid slot per rw value.

## Timing
- `bubble` and `full` are purely combinational from the inputs and registered slot state; there is no registered output except stall_cnt.
- Latency semantics: a producer issued at edge t with id_lat = L blocks a dependent ID instruction during cycles t+1 .. t+L; it is released in cycle t+L+1. The existing MFC0 case uses L = 2, which gives 2 bubbles to the adjacent consumer and 1 to a consumer one instruction behind.
- advance = 0 freezes allocation but not decrement. Countdowns are wall-clock, because EX/MEM keep moving during ID-only stalls.
- A slot with cnt = 1 may be reallocated at the same edge it expires.
- Reset mid-operation: all slots clear asynchronously, `bubble` = 0 as soon as rst_n is low, and stall_cnt = 0.

## Configuration
- HAZ_STATS_EN defined: stall_cnt increments each edge where bubble = 1, and saturates at 0xFFFFFFFF. flush does not clear it; only reset does.
- HAZ_STATS_EN undefined: the stall_cnt port remains and is tied to 0. No counter flops are synthesised.

## Test plan
- Producer MFC0 to $5 with id_lat = 2 issues, then the next instruction reads $5 as src0 -> bubble = 1 for exactly 2 cycles, then issues; with HAZ_STATS_EN, stall_cnt = 2.
- Producer to $0 with id_lat = 3, then a reader of $0 -> no slot allocated, bubble never asserted.
- Fill 4 slots with $1..$4 at id_lat = 7, then an ID instruction with id_rw = $9, id_lat = 2 and no matching sources -> full = 1 and bubble = 1 until the first slot reaches cnt = 1, then it allocates into slot 0.
- $6 issued with id_lat = 5, then $6 reissued with id_lat = 1 two cycles later -> the same slot is reloaded, a $6 reader stalls only 1 cycle after the second issue, and no second slot is used.
- 3 slots valid, flush pulsed for one cycle while ID holds a dependent reader -> bubble = 0 during the flush, all slots are empty next cycle, and the reader issues.
- rst_n driven low mid-countdown with bubble = 1 -> bubble drops immediately; after release no stall occurs and stall_cnt = 0.
